// File: rtl/imm_ext_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : ext_defs
// Brief   : Immediate-extension mode encodings shared by decode and issue.
// Rev     : 1.0  initial release
// ============================================================================
package ext_defs;

    localparam int EXT_MODE_W = 2;

    typedef logic [EXT_MODE_W-1:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO  = 2'd0;
    localparam ext_mode_t EXT_SIGN  = 2'd1;
    localparam ext_mode_t EXT_ONES  = 2'd2;
    localparam ext_mode_t EXT_UPPER = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ext_lane.sv
`default_nettype none
// ============================================================================
// Module : ext_lane
// Brief  : Combinational single-lane immediate extender with lane enable.
// Rev    : 1.0  initial release
// ============================================================================
module ext_lane
    import ext_defs::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  i_imm,
    input  ext_mode_t        i_mode,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_ext
);

    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_ones;
    logic [OUT_W-1:0] w_upper;

    // Casts and shifts keep every form legal when OUT_W equals IN_W.
    assign w_zero  = OUT_W'(i_imm);
    assign w_sign  = OUT_W'($signed(i_imm));
    assign w_ones  = w_zero | ~OUT_W'({IN_W{1'b1}});
    assign w_upper = w_zero << (OUT_W - IN_W);

    always_comb begin
        o_ext = '0;
        if (i_en) begin
            case (i_mode)
                EXT_ZERO:  o_ext = w_zero;
                EXT_SIGN:  o_ext = w_sign;
                EXT_ONES:  o_ext = w_ones;
                EXT_UPPER: o_ext = w_upper;
                default:   o_ext = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module : imm_ext_pipe
// Brief  : Multi-lane immediate extender with registered output and skid buffer.
// Rev    : 1.0  initial release
// ============================================================================
module imm_ext_pipe
    import ext_defs::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int LANES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*IN_W-1:0]       in_imm,
    input  logic [LANES*EXT_MODE_W-1:0] in_mode,
    input  logic [LANES-1:0]            in_lane_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*OUT_W-1:0]      out_imm,
    output logic [LANES-1:0]            out_lane_en
);

    localparam logic [1:0] C_EMPTY = 2'd0;
    localparam logic [1:0] C_ONE   = 2'd1;
    localparam logic [1:0] C_FULL  = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   r_in_ready;
    logic [LANES*OUT_W-1:0] w_ext;
    logic [LANES*OUT_W-1:0] r_main_imm;
    logic [LANES*OUT_W-1:0] r_skid_imm;
    logic [LANES-1:0]       r_main_en;
    logic [LANES-1:0]       r_skid_en;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_load_main_in;
    logic                   w_load_main_skid;
    logic                   w_load_skid;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            ext_lane #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_ext_lane (
                .i_imm  (in_imm[g*IN_W +: IN_W]),
                .i_mode (in_mode[g*EXT_MODE_W +: EXT_MODE_W]),
                .i_en   (in_lane_en[g]),
                .o_ext  (w_ext[g*OUT_W +: OUT_W])
            );
        end
    endgenerate

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = out_ready && (r_state != C_EMPTY);

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= C_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != C_FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_EMPTY: if (w_in_xfer) w_state_nxt = C_ONE;
            C_ONE: begin
                if (w_in_xfer && !w_out_xfer)      w_state_nxt = C_FULL;
                else if (!w_in_xfer && w_out_xfer) w_state_nxt = C_EMPTY;
            end
            C_FULL:  if (w_out_xfer) w_state_nxt = C_ONE;
            default: w_state_nxt = C_EMPTY;
        endcase
    end

    always_comb begin
        out_valid        = (r_state != C_EMPTY);
        w_load_main_in   = w_in_xfer && ((r_state == C_EMPTY) || ((r_state == C_ONE) && w_out_xfer));
        w_load_skid      = w_in_xfer && (r_state == C_ONE) && !w_out_xfer;
        w_load_main_skid = (r_state == C_FULL) && w_out_xfer;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_imm <= '0;
            r_main_en  <= '0;
            r_skid_imm <= '0;
            r_skid_en  <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_imm <= w_ext;
                r_main_en  <= in_lane_en;
            end else if (w_load_main_skid) begin
                r_main_imm <= r_skid_imm;
                r_main_en  <= r_skid_en;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_ext;
                r_skid_en  <= in_lane_en;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_imm     = r_main_imm;
    assign out_lane_en = r_main_en;

    // Upstream must hold a stalled bundle unchanged until it is accepted.
    a_in_hold: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_imm) && $stable(in_mode) && $stable(in_lane_en)));

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_imm_ext_pipe
// Brief  : Self-checking bench for imm_ext_pipe against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_imm_ext_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [1:0]  en;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_imm = '0;
    logic [3:0]  in_mode = '0;
    logic [1:0]  in_lane_en = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_imm;
    logic [1:0]  out_lane_en;

    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic [31:0] d_in_imm = '0;
    logic [3:0]  d_in_mode = '0;
    logic [1:0]  d_in_lane_en = '0;
    logic        d_out_valid;
    logic [31:0] d_out_imm;
    logic [1:0]  d_out_lane_en;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .LANES(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_lane_en(in_lane_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_lane_en(out_lane_en)
    );

    imm_ext_pipe #(.IN_W(16), .OUT_W(16), .LANES(2)) u_deg (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_imm(d_in_imm), .in_mode(d_in_mode), .in_lane_en(d_in_lane_en),
        .out_valid(d_out_valid), .out_ready(1'b1),
        .out_imm(d_out_imm), .out_lane_en(d_out_lane_en)
    );

    // Extension rules as plain arithmetic on the 16-bit value.
    function automatic logic [31:0] lane_model(input logic [15:0] x, input logic [1:0] m, input logic en);
        longint v;
        v = longint'(x);
        if (!en) return 32'h0;
        case (m)
            2'd1:    if (x >= 16'h8000) v = v - 65536 + 64'h1_0000_0000;
            2'd2:    v = v + 64'hFFFF_0000;
            2'd3:    v = v * 65536;
            default: v = v;
        endcase
        return v[31:0];
    endfunction

    function automatic exp_t bundle_model(input logic [31:0] imm, input logic [3:0] mode, input logic [1:0] en);
        exp_t e;
        e.imm = {lane_model(imm[31:16], mode[3:2], en[1]), lane_model(imm[15:0], mode[1:0], en[0])};
        e.en  = en;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: outputs are stable mid-cycle, and the handshake seen here is what the next edge commits.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_out", {63'b0, out_valid}, 64'd0);
                end else begin
                    chk("sb_imm", out_imm, q[0].imm);
                    chk("sb_en", {62'b0, out_lane_en}, {62'b0, q[0].en});
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back(bundle_model(in_imm, in_mode, in_lane_en));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] i0, input logic [1:0] m0,
                         input logic [15:0] i1, input logic [1:0] m1, input logic [1:0] en);
        in_imm     = {i1, i0};
        in_mode    = {m1, m0};
        in_lane_en = en;
        in_valid   = 1'b1;
    endtask

    task automatic wait_accept;
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] i0, input logic [1:0] m0,
                        input logic [15:0] i1, input logic [1:0] m1, input logic [1:0] en);
        drive(i0, m0, i1, m1, en);
        wait_accept();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        chk("model_sign",  {32'b0, lane_model(16'h8001, 2'd1, 1'b1)}, 64'hFFFF_8001);
        chk("model_ones",  {32'b0, lane_model(16'h1234, 2'd2, 1'b1)}, 64'hFFFF_1234);
        chk("model_upper", {32'b0, lane_model(16'h1234, 2'd3, 1'b1)}, 64'h1234_0000);
        chk("model_off",   {32'b0, lane_model(16'h1234, 2'd2, 1'b0)}, 64'h0);

        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'b0, in_ready},  64'd0);
        chk("rst_out_imm",   out_imm, 64'd0);
        chk("rst_out_en",    {62'b0, out_lane_en}, 64'd0);
        tick();
        tick();
        chk("rst_hold_in_ready", {63'b0, in_ready}, 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("post_rst_out_valid", {63'b0, out_valid}, 64'd0);

        // Lane modes, one-cycle latency, single-cycle valid
        out_ready = 1'b1;
        send(16'h8001, 2'd1, 16'h8001, 2'd0, 2'b11);
        chk("t1_valid", {63'b0, out_valid}, 64'd1);
        chk("t1_imm",   out_imm, 64'h00008001_FFFF8001);
        chk("t1_en",    {62'b0, out_lane_en}, 64'd3);
        tick();
        chk("t1_valid_one_cycle", {63'b0, out_valid}, 64'd0);

        // Ones, upper, disabled lane
        send(16'h1234, 2'd2, 16'h1234, 2'd3, 2'b11);
        chk("t2_imm", out_imm, 64'h12340000_FFFF1234);
        send(16'h1234, 2'd2, 16'h1234, 2'd3, 2'b01);
        chk("t2_dis_imm", out_imm, 64'h00000000_FFFF1234);
        chk("t2_dis_en",  {62'b0, out_lane_en}, 64'd1);
        tick();

        // Backpressure into the skid register
        out_ready = 1'b0;
        send(16'h000A, 2'd0, 16'hA000, 2'd1, 2'b11);
        send(16'h000B, 2'd2, 16'h00B0, 2'd3, 2'b11);
        drive(16'h00C0, 2'd1, 16'hC000, 2'd0, 2'b11);
        chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        chk("bp_hold_a", out_imm, 64'hFFFFA000_0000000A);
        tick();
        tick();
        chk("bp_still_low", {63'b0, in_ready}, 64'd0);
        chk("bp_still_a", out_imm, 64'hFFFFA000_0000000A);
        out_ready = 1'b1;
        tick();
        chk("bp_b", out_imm, 64'h00B00000_FFFF000B);
        chk("bp_ready_back", {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_c", out_imm, 64'h0000C000_000000C0);
        chk("bp_c_valid", {63'b0, out_valid}, 64'd1);
        tick();
        chk("bp_drained", {63'b0, out_valid}, 64'd0);

        // Streaming: 100 back-to-back bundles
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            drive(16'(i), 2'd0, 16'(i) + 16'h8000, 2'd1, 2'b11);
            tick();
            chk("stream_no_bubble", {63'b0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream_count", 64'(n_out - base), 64'd100);

        // Asynchronous reset with the pipe full
        out_ready = 1'b0;
        send(16'h1111, 2'd0, 16'h2222, 2'd0, 2'b11);
        send(16'h3333, 2'd0, 16'h4444, 2'd0, 2'b11);
        chk("rst_full", {63'b0, in_ready}, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst_in_ready",  {63'b0, in_ready},  64'd0);
        chk("arst_out_imm",   out_imm, 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arst_rel_in_ready", {63'b0, in_ready}, 64'd1);
        chk("arst_rel_valid", {63'b0, out_valid}, 64'd0);
        tick();
        chk("arst_rel_valid2", {63'b0, out_valid}, 64'd0);
        send(16'h0005, 2'd3, 16'hFFFF, 2'd1, 2'b10);
        chk("arst_new", out_imm, 64'hFFFFFFFF_00000000);
        chk("arst_new_en", {62'b0, out_lane_en}, 64'd2);
        tick();

        // Equal widths: UPPER and SIGN both pass the value through
        d_in_imm     = 32'hABCD_ABCD;
        d_in_mode    = {2'd1, 2'd3};
        d_in_lane_en = 2'b11;
        d_in_valid   = 1'b1;
        chk("deg_ready", {63'b0, d_in_ready}, 64'd1);
        tick();
        d_in_valid = 1'b0;
        chk("deg_valid", {63'b0, d_out_valid}, 64'd1);
        chk("deg_imm", {32'b0, d_out_imm}, 64'hABCDABCD);
        chk("deg_en", {62'b0, d_out_lane_en}, 64'd3);
        tick();

        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
